// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Multi-channel push-button front end for the RPN calculator. Each channel
// turns a raw, bouncing, asynchronous button level into a clean debounced
// level plus single-cycle press/release pulses for the control FSM
// (ch0 = Enter, ch1 = Undo; btn_press drives EnterPulse/Undo).
//
// Per channel:
//   btn_in -> sync1 -> sync2 (2-FF synchronizer)
//   sync2  -> 4-state debounce FSM (LOW / CHK_HIGH / HIGH / CHK_LOW)
//   A new level is accepted only after N_DEBOUNCER consecutive identical
//   synchronized samples; any shorter excursion returns to the prior state.
//
// Parameters:
//   N_CH         number of independent button channels
//   N_DEBOUNCER  identical samples needed to accept a new level (>= 2)
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   reset        synchronous reset, active-low (0 = reset)
//   btn_in       raw asynchronous button levels, 1 = pressed
//   btn_level    debounced level per channel (registered)
//   btn_press    one-cycle pulse on an accepted 0->1 transition (registered)
//   btn_release  one-cycle pulse on an accepted 1->0 transition (registered)
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int N_CH        = 2,
  parameter int N_DEBOUNCER = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release
);

  // Counter only has to reach N_DEBOUNCER-1, so this width can never wrap.
  localparam int CW = $clog2(N_DEBOUNCER + 1);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_DEBOUNCER - 1);

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_CHK_HIGH = 2'd1,
    ST_HIGH     = 2'd2,
    ST_CHK_LOW  = 2'd3
  } state_t;

  // Two-flop synchronizer for all channels. Only sync2_q is ever looked at
  // by the debounce logic; sync1_q exists purely to let metastability settle.
  logic [N_CH-1:0] sync1_q;
  logic [N_CH-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  // One independent debounce FSM per channel.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_inc_d;
    logic            cnt_last;
    logic            level_q;
    logic            press_q;
    logic            release_q;
    logic            sample;

    assign sample    = sync2_q[g];
    assign cnt_inc_d = cnt_q + CNT_ONE;
    assign cnt_last  = (cnt_q == CNT_LAST);

    // Debounce FSM with registered outputs. The pulses default low every
    // cycle, so they only ever last the single cycle after an accepting edge,
    // and press/release come from mutually exclusive branches so they can
    // never be high together. Reset takes priority over every transition.
    always_ff @(posedge clk) begin
      if (!reset) begin
        state_q   <= ST_LOW;
        cnt_q     <= CNT_ZERO;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        unique case (state_q)
          ST_LOW: begin
            if (sample) begin
              state_q <= ST_CHK_HIGH;
              cnt_q   <= CNT_ONE;
            end else begin
              cnt_q   <= CNT_ZERO;
            end
          end

          // A single low sample aborts qualification and discards the count.
          ST_CHK_HIGH: begin
            if (!sample) begin
              state_q <= ST_LOW;
              cnt_q   <= CNT_ZERO;
            end else if (cnt_last) begin
              state_q <= ST_HIGH;
              cnt_q   <= CNT_ZERO;
              level_q <= 1'b1;
              press_q <= 1'b1;
            end else begin
              cnt_q   <= cnt_inc_d;
            end
          end

          // Held button: stay here forever, no auto-repeat.
          ST_HIGH: begin
            if (!sample) begin
              state_q <= ST_CHK_LOW;
              cnt_q   <= CNT_ONE;
            end else begin
              cnt_q   <= CNT_ZERO;
            end
          end

          ST_CHK_LOW: begin
            if (sample) begin
              state_q   <= ST_HIGH;
              cnt_q     <= CNT_ZERO;
            end else if (cnt_last) begin
              state_q   <= ST_LOW;
              cnt_q     <= CNT_ZERO;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              cnt_q     <= cnt_inc_d;
            end
          end

          default: begin
            state_q <= ST_LOW;
            cnt_q   <= CNT_ZERO;
          end
        endcase
      end
    end

    assign btn_level[g]   = level_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Self-checking bench for button_conditioner (N_CH=2, N_DEBOUNCER=4).
// Every driven cycle runs a small run-length reference model of the
// synchronizer + debouncer, pushes the expected outputs onto a scoreboard
// queue, and pops/compares them one time unit after the clock edge.
// Directed scenarios add explicit timing and pulse-count checks on top.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int N_CH  = 2;
  localparam int N_DEB = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N_CH-1:0] btn_in = '0;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] btn_press;
  logic [N_CH-1:0] btn_release;

  button_conditioner #(
    .N_CH        (N_CH),
    .N_DEBOUNCER (N_DEB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] rel;
  } exp_t;

  exp_t expQ[$];

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state: synchronizer copy, current run of identical
  // synchronized samples per channel, and the accepted level.
  logic [N_CH-1:0] mS1 = '0;
  logic [N_CH-1:0] mS2 = '0;
  logic [N_CH-1:0] mLevel = '0;
  logic [N_CH-1:0] mRunVal = '0;
  int              mRunLen [N_CH];

  int pressSeen   [N_CH];
  int releaseSeen [N_CH];

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic clearCounts();
    for (int ch = 0; ch < N_CH; ch++) begin
      pressSeen[ch]   = 0;
      releaseSeen[ch] = 0;
    end
  endtask

  // Advance the model by one rising edge. A level is accepted when the
  // run of identical synchronized samples reaches N_DEB and differs from
  // the current level.
  task automatic modelEdge(input logic rst, input logic [N_CH-1:0] btn, output exp_t e);
    logic [N_CH-1:0] sample;
    e = '0;
    if (!rst) begin
      mS1    = '0;
      mS2    = '0;
      mLevel = '0;
      mRunVal = '0;
      for (int ch = 0; ch < N_CH; ch++) mRunLen[ch] = 0;
    end else begin
      sample = mS2;
      mS2    = mS1;
      mS1    = btn;
      for (int ch = 0; ch < N_CH; ch++) begin
        if (mRunLen[ch] > 0 && sample[ch] == mRunVal[ch]) mRunLen[ch]++;
        else begin
          mRunVal[ch] = sample[ch];
          mRunLen[ch] = 1;
        end
        if (mRunLen[ch] >= N_DEB && mRunVal[ch] != mLevel[ch]) begin
          mLevel[ch] = mRunVal[ch];
          if (mRunVal[ch]) e.press[ch] = 1'b1;
          else             e.rel[ch]   = 1'b1;
        end
      end
    end
    e.level = mLevel;
  endtask

  // Drive one cycle of stimulus, queue the model's prediction, then
  // compare against the DUT just after the edge.
  task automatic applyStimulus(input logic rst, input logic [N_CH-1:0] btn, input string tag);
    exp_t e;
    exp_t got;
    reset  = rst;
    btn_in = btn;
    modelEdge(rst, btn, e);
    expQ.push_back(e);
    @(posedge clk);
    #1;
    got = expQ.pop_front();
    checkOutput({tag, "_level"},   32'(btn_level),   32'(got.level));
    checkOutput({tag, "_press"},   32'(btn_press),   32'(got.press));
    checkOutput({tag, "_release"}, 32'(btn_release), 32'(got.rel));
    for (int ch = 0; ch < N_CH; ch++) begin
      pressSeen[ch]   += int'(btn_press[ch]);
      releaseSeen[ch] += int'(btn_release[ch]);
    end
  endtask

  initial begin
    logic [N_CH-1:0] rnd;
    logic            rrst;
    clearCounts();
    for (int ch = 0; ch < N_CH; ch++) mRunLen[ch] = 0;

    // 1: reset with both buttons held, then re-qualify after release.
    for (int i = 1; i <= 3; i++) applyStimulus(1'b0, 2'b11, "t1_rst");
    checkOutput("t1_rst_outputs", 32'({btn_level, btn_press, btn_release}), 32'd0);
    clearCounts();
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 2'b11, "t1_run");
      if (i == 5) checkOutput("t1_press_e5", 32'(btn_press), 32'd0);
      if (i == 6) checkOutput("t1_press_e6", 32'(btn_press), 32'b11);
      if (i == 6) checkOutput("t1_level_e6", 32'(btn_level), 32'b11);
      if (i == 7) checkOutput("t1_press_e7", 32'(btn_press), 32'd0);
    end
    for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 2'b00, "t1_idle");

    // 2: clean press on channel 0 only.
    clearCounts();
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 2'b01, "t2_press");
      if (i == 6) checkOutput("t2_press_e6", 32'(btn_press), 32'b01);
    end
    checkOutput("t2_level", 32'(btn_level), 32'b01);
    checkOutput("t2_press_cnt1", 32'(pressSeen[1]), 32'd0);
    checkOutput("t2_release_cnt0", 32'(releaseSeen[0]), 32'd0);
    for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 2'b00, "t2_idle");

    // 3: bounce 1,1,1,0 then stable 1 -> a single press, late.
    clearCounts();
    begin
      logic [7:0] bounce;
      bounce = 8'b1111_0111;
      for (int i = 0; i < 8; i++) begin
        applyStimulus(1'b1, {1'b0, bounce[i]}, "t3_bounce");
        if (i == 5) checkOutput("t3_no_early_press", 32'(pressSeen[0]), 32'd0);
      end
    end
    for (int i = 1; i <= 6; i++) applyStimulus(1'b1, 2'b01, "t3_hold");
    checkOutput("t3_press_cnt0", 32'(pressSeen[0]), 32'd1);
    checkOutput("t3_level", 32'(btn_level), 32'b01);

    // 4: release channel 0 from HIGH.
    clearCounts();
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 2'b00, "t4_release");
      if (i == 6) checkOutput("t4_release_e6", 32'(btn_release), 32'b01);
    end
    checkOutput("t4_level", 32'(btn_level), 32'd0);
    checkOutput("t4_release_cnt0", 32'(releaseSeen[0]), 32'd1);
    checkOutput("t4_press_cnt0", 32'(pressSeen[0]), 32'd0);

    // 5: hold channel 1 for 100 cycles, no auto-repeat.
    clearCounts();
    for (int i = 1; i <= 100; i++) begin
      applyStimulus(1'b1, 2'b10, "t5_hold");
      if (i >= 6) checkOutput("t5_hold_level1", 32'(btn_level[1]), 32'd1);
    end
    checkOutput("t5_press_cnt1", 32'(pressSeen[1]), 32'd1);
    for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 2'b00, "t5_idle");

    // 6: reset in the middle of qualification, then re-qualify.
    clearCounts();
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 2'b01, "t6_pre");
    applyStimulus(1'b0, 2'b01, "t6_rst");
    checkOutput("t6_rst_outputs", 32'({btn_level, btn_press, btn_release}), 32'd0);
    applyStimulus(1'b0, 2'b01, "t6_rst");
    for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 2'b01, "t6_requal");
    checkOutput("t6_press_cnt0", 32'(pressSeen[0]), 32'd1);
    checkOutput("t6_level", 32'(btn_level), 32'b01);

    // Random noisy inputs with occasional reset, fully model-checked.
    rnd = 2'b00;
    for (int i = 0; i < 300; i++) begin
      for (int ch = 0; ch < N_CH; ch++)
        if ($urandom_range(5) == 0) rnd[ch] = ~rnd[ch];
      rrst = ($urandom_range(99) != 0);
      applyStimulus(rrst, rnd, "rand");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
